// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch counting rising edges of a slow time-base level.
// The time-base is synchronised and edge-detected in the clk_in domain.
module bcd_stopwatch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          WRAP_EN     = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_evt;
    logic                   at_max;
    logic                   halt_now;
    logic [3:0]             su_n, st_n, mu_n, mt_n;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_evt = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign at_max   = ({min_tens, min_units, sec_tens, sec_units} == 16'h5959);
    assign halt_now = tick_evt & at_max & ~WRAP_EN;

    // Ripple-carry increment; at 59:59 this naturally yields 00:00.
    always_comb begin
        su_n = sec_units + 4'd1;
        st_n = sec_tens;
        mu_n = min_units;
        mt_n = min_tens;
        if (sec_units == 4'd9) begin
            su_n = 4'd0;
            st_n = sec_tens + 4'd1;
            if (sec_tens == 4'd5) begin
                st_n = 4'd0;
                mu_n = min_units + 4'd1;
                if (min_units == 4'd9) begin
                    mu_n = 4'd0;
                    mt_n = (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sec_units <= '0;
            sec_tens  <= '0;
            min_units <= '0;
            min_tens  <= '0;
            running   <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            rollover <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                sec_units <= '0;
                sec_tens  <= '0;
                min_units <= '0;
                min_tens  <= '0;
                running   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick_evt) begin
                            rollover <= at_max;
                            if (!halt_now) begin
                                sec_units <= su_n;
                                sec_tens  <= st_n;
                                min_units <= mu_n;
                                min_tens  <= mt_n;
                            end
                        end
                        // Saturation takes priority over a coincident pause request.
                        if (halt_now) begin
                            state   <= HALT;
                            running <= 1'b0;
                        end else if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    HALT: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomised bench for bcd_stopwatch: a wrapping and a saturating instance
// share stimulus and are compared every cycle against a seconds-count model.
module tb_bcd_stopwatch;

    localparam int unsigned SYNC = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

    logic       clk_in = 1'b0;
    logic       rst_n, tick_in, start_stop, clear;
    logic [3:0] w_su, w_st, w_mu, w_mt, h_su, h_st, h_mu, h_mt;
    logic       w_run, w_roll, h_run, h_roll;

    int checks = 0;
    int errors = 0;

    logic hist [0:SYNC];
    int   m_secs [2];
    int   m_mode [2];
    bit   m_roll [2];
    int   obs_roll_cnt [2];

    bcd_stopwatch #(.SYNC_STAGES(SYNC), .WRAP_EN(1'b1)) dut_w (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear),
        .sec_units(w_su), .sec_tens(w_st), .min_units(w_mu), .min_tens(w_mt),
        .running(w_run), .rollover(w_roll)
    );

    bcd_stopwatch #(.SYNC_STAGES(SYNC), .WRAP_EN(1'b0)) dut_h (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
        .start_stop(start_stop), .clear(clear),
        .sec_units(h_su), .sec_tens(h_st), .min_units(h_mu), .min_tens(h_mt),
        .running(h_run), .rollover(h_roll)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        int s;
        s = m_secs[i];
        model_word = 32'(((s / 600) << 14) | (((s / 60) % 10) << 10) |
                         (((s / 10) % 6) << 6) | ((s % 10) << 2) |
                         ((m_mode[i] == M_RUN ? 1 : 0) << 1) | (m_roll[i] ? 1 : 0));
    endfunction

    function automatic logic [31:0] obs_word(input int i);
        if (i == 0) obs_word = {14'b0, w_mt, w_mu, w_st, w_su, w_run, w_roll};
        else        obs_word = {14'b0, h_mt, h_mu, h_st, h_su, h_run, h_roll};
    endfunction

    function automatic logic [15:0] digits(input int i);
        if (i == 0) digits = {w_mt, w_mu, w_st, w_su};
        else        digits = {h_mt, h_mu, h_st, h_su};
    endfunction

    function automatic bit next_evt();
        next_evt = hist[SYNC-1] & ~hist[SYNC];
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0;
            m_mode[i] = M_IDLE;
            m_roll[i] = 1'b0;
        end
    endtask

    task automatic model_upd(input int i, input bit evt, input bit ss, input bit clr);
        m_roll[i] = 1'b0;
        if (clr) begin
            m_secs[i] = 0;
            m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSE) begin
            if (ss) m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN) begin
            if (evt) begin
                if (m_secs[i] == 3599) begin
                    m_roll[i] = 1'b1;
                    if (i == 0) m_secs[i] = 0;
                    else        m_mode[i] = M_HALT;
                end else begin
                    m_secs[i] = m_secs[i] + 1;
                end
            end
            if (ss && m_mode[i] == M_RUN) m_mode[i] = M_PAUSE;
        end
    endtask

    task automatic step(input bit ss, input bit clr);
        bit evt;
        start_stop = ss;
        clear      = clr;
        evt = next_evt();
        model_upd(0, evt, ss, clr);
        model_upd(1, evt, ss, clr);
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = tick_in;
        @(posedge clk_in);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        if (w_roll === 1'b1) obs_roll_cnt[0]++;
        if (h_roll === 1'b1) obs_roll_cnt[1]++;
        chk("cycle_wrap_inst", obs_word(0), model_word(0));
        chk("cycle_halt_inst", obs_word(1), model_word(1));
    endtask

    task automatic one_tick();
        tick_in = 1'b1;
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        tick_in = 1'b0;
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) one_tick();
        repeat (SYNC + 2) step(1'b0, 1'b0);
    endtask

    // Raise tick_in and apply the pulses on the cycle the detected edge is live.
    task automatic tick_with(input bit ss, input bit clr);
        bit done;
        done = 1'b0;
        tick_in = 1'b1;
        for (int k = 0; k < int'(SYNC) + 3 && !done; k++) begin
            if (next_evt()) begin
                step(ss, clr);
                done = 1'b1;
            end else begin
                step(1'b0, 1'b0);
            end
        end
        tick_in = 1'b0;
        repeat (SYNC + 2) step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit tick_level);
        tick_in = tick_level;
        #3 rst_n = 1'b0;
        #1;
        chk("reset_async_wrap", obs_word(0), 32'h0);
        chk("reset_async_halt", obs_word(1), 32'h0);
        model_clear();
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        obs_roll_cnt[0] = 0; obs_roll_cnt[1] = 0;
        model_clear();
        #1;
        chk("reset_initial", obs_word(0), 32'h0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        // Count to 12:34, then reset asynchronously mid-cycle.
        step(1'b1, 1'b0);
        ticks(754);
        chk("t1_preload_1234", digits(0), 16'h1234);
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0);
        chk("t1_idle_after_reset", w_run, 1'b0);

        // Level already high at release produces an edge that IDLE ignores.
        do_reset(1'b1);
        repeat (SYNC + 4) step(1'b0, 1'b0);
        tick_in = 1'b0;
        repeat (SYNC + 2) step(1'b0, 1'b0);
        chk("reset_high_tick_ignored", digits(0), 16'h0000);

        // Latency, and a long high level counts exactly once.
        step(1'b1, 1'b0);
        tick_in = 1'b1;
        repeat (SYNC) step(1'b0, 1'b0);
        chk("t2_not_yet", w_su, 4'd0);
        step(1'b0, 1'b0);
        chk("t2_latency", w_su, 4'd1);
        repeat (1000 - SYNC - 1) step(1'b0, 1'b0);
        tick_in = 1'b0;
        repeat (SYNC + 2) step(1'b0, 1'b0);
        chk("t2_long_level_once", digits(0), 16'h0001);

        // Carries, full range, wrap and saturation.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        ticks(599);
        chk("t3_0959", digits(0), 16'h0959);
        ticks(1);
        chk("t3_1000", digits(0), 16'h1000);
        ticks(2999);
        chk("t3_5959_wrap", digits(0), 16'h5959);
        chk("t3_5959_halt", digits(1), 16'h5959);
        obs_roll_cnt[0] = 0; obs_roll_cnt[1] = 0;
        ticks(1);
        chk("t4_wrap_0000", digits(0), 16'h0000);
        chk("t4_wrap_running", w_run, 1'b1);
        chk("t4_wrap_roll_cnt", obs_roll_cnt[0], 1);
        chk("t4_halt_5959", digits(1), 16'h5959);
        chk("t4_halt_stopped", h_run, 1'b0);
        chk("t4_halt_roll_cnt", obs_roll_cnt[1], 1);
        ticks(4);
        step(1'b1, 1'b0);
        ticks(3);
        chk("t4_halt_ignores", digits(1), 16'h5959);
        chk("t4_halt_ignores_ss", h_run, 1'b0);
        step(1'b0, 1'b1);
        chk("t4_clear_halt", obs_word(1), 32'h0);

        // Pause holds the count.
        step(1'b1, 1'b0);
        ticks(7);
        step(1'b1, 1'b0);
        ticks(5);
        chk("t5_paused_0007", digits(0), 16'h0007);
        chk("t5_paused_flag", w_run, 1'b0);
        step(1'b1, 1'b0);
        ticks(1);
        chk("t5_resumed_0008", digits(0), 16'h0008);

        // Collisions.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        ticks(4);
        tick_with(1'b1, 1'b0);
        chk("t6_run_ss_tick", digits(0), 16'h0005);
        chk("t6_run_ss_tick_paused", w_run, 1'b0);
        step(1'b0, 1'b1);
        tick_with(1'b1, 1'b0);
        chk("t6_idle_ss_tick", digits(0), 16'h0000);
        chk("t6_idle_ss_tick_run", w_run, 1'b1);
        ticks(201);
        chk("t6_preload_0321", digits(0), 16'h0321);
        tick_with(1'b1, 1'b1);
        chk("t6_clear_wins", obs_word(0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
